rv32_mem_target: RTL

RV32_MEM_TARGET -- requirements
Module: rv32_mem_target

---
 rtl/rv32_mem_pkg.sv | 19 +
 rtl/rv32_mem_ram.sv | 32 +++
 rtl/rv32_mem_target.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and address map for the rv32 memory target.
// Imported by the RAM and the target top.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR     = 32'h0001_0000;
  localparam logic [31:0] COUNTER_ADDR = 32'h0001_0004;

  function automatic logic word_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rv32_mem_ram.sv
// Word RAM with byte-masked synchronous write and registered read.
// Written in the plain template that maps onto block RAM.
module rv32_mem_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [3:0]    i_wmask,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_wmask[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv32_mem_target.sv
// Single-outstanding load/store target: RAM, LED register, cycle counter.
// Response appears WAIT_STATES+1 cycles after the request is accepted.
module rv32_mem_target
  import rv32_mem_pkg::*;
#(
  parameter int RAM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [3:0]  WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      r_state;
  logic [3:0]  r_wcnt;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;
  logic        r_err;
  logic        r_from_ram;
  logic [31:0] r_hold;
  logic [7:0]  r_leds;
  logic [31:0] r_cnt;

  logic        w_hs;
  logic        w_ram_hit;
  logic        w_led_hit;
  logic        w_cnt_hit;
  logic        w_err;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_ram_rdata;

  assign w_hs      = req_valid && (r_state == S_IDLE);
  assign w_ram_hit = (req_addr - RAM_BASE) < RAM_BYTES;
  assign w_led_hit = req_addr == LED_ADDR;
  assign w_cnt_hit = req_addr == COUNTER_ADDR;

  // Errors block every side effect, including RAM and LED writes.
  assign w_err = !word_aligned(req_addr)
              || !(w_ram_hit || w_led_hit || w_cnt_hit)
              || (w_cnt_hit && req_write);

  assign w_ram_we = w_hs && req_write && w_ram_hit && !w_err;
  assign w_ram_re = w_hs && !req_write && w_ram_hit && !w_err;

  rv32_mem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_wmask (req_wmask),
    .i_addr  (req_addr[AW+1:2]),
    .i_wdata (req_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wcnt       <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
      r_err        <= 1'b0;
      r_from_ram   <= 1'b0;
      r_hold       <= 32'h0;
      r_leds       <= 8'h0;
      r_cnt        <= 32'h0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_err      <= w_err;
            r_from_ram <= w_ram_re;
            if (w_err || req_write) begin
              r_hold <= 32'h0;
            end else if (w_led_hit) begin
              r_hold <= {24'h0, r_leds};
            end else if (w_cnt_hit) begin
              r_hold <= r_cnt;
            end else begin
              r_hold <= 32'h0;
            end
            if (req_write && w_led_hit && !w_err
                && req_wmask[0]) begin
              r_leds <= req_wdata[7:0];
            end
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_wcnt  <= WS_LOAD;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_RESP: begin
          // First RESP cycle latches the RAM read port output.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_error <= r_err;
            r_resp_rdata <= r_from_ram ? w_ram_rdata : r_hold;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_state == S_IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign leds       = r_leds;

endmodule
